// File: rtl/bridge_pkg.sv
// Shared types and helpers for the SRAM-to-AXI bridge.
package bridge_pkg;

  typedef enum logic [1:0] {RIdle, RAr, RWait} rd_state_e;
  typedef enum logic [1:0] {WIdle, WSend, WResp} wr_state_e;

  localparam logic [3:0] DefaultInstId = 4'd0;
  localparam logic [3:0] DefaultDataId = 4'd1;

  // SRAM size code (0/1/2 = byte/half/word) maps directly onto AXI AxSIZE.
  function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_wr_ctrl.sv
// Write-side controller: one AXI write (AW + W + B) at a time for the data master.
// AW and W are issued together and retire independently.
module sram_axi_wr_ctrl
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        accept_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  output logic        idle_o,
  output logic        done_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  wr_state_e   state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;

  // State, handshake flags and latched payload.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= WIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (accept_i) begin
        addr_q  <= addr_i;
        size_q  <= size_to_axsize(size_i);
        wstrb_q <= wstrb_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // Next state and channel valids/readies.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      WIdle: if (accept_i) state_d = WSend;
      WSend: begin
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        if (!aw_done_q && awready_i) aw_done_d = 1'b1;
        if (!w_done_q && wready_i) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = WResp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WResp: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          done_o  = 1'b1;
          state_d = WIdle;
        end
      end
      default: state_d = WIdle;
    endcase
  end

  assign idle_o   = (state_q == WIdle);
  assign awaddr_o = addr_q;
  assign awsize_o = size_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the inst and data SRAM-like ports onto one AXI master.
// Optional macro BRIDGE_RAW_ADDR_CMP_EN: inst reads stall behind an in-flight write only
// when they hit the same word; otherwise any in-flight write stalls inst reads.
module sram_axi_bridge
  import bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = DefaultInstId,
  parameter logic [3:0] DATA_ID = DefaultDataId
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [2:0]  ar_size_q, ar_size_d;
  logic [3:0]  ar_id_q, ar_id_d;

  logic wr_idle, wr_done, wr_accept;
  logic data_busy, data_rd_grant, inst_grant, inst_hazard;
  logic rsp_inst, rsp_data;

  // The inst port is read-only; its write-side inputs carry no meaning.
  logic unused_inst;
  assign unused_inst = ^{inst_wr, inst_wstrb, inst_wdata};

  // Data master allows one outstanding transaction of either kind.
  assign data_busy     = ((rd_state_q != RIdle) && (ar_id_q == DATA_ID)) || !wr_idle;
  assign data_rd_grant = resetn && (rd_state_q == RIdle) && data_req && !data_wr && !data_busy;
  assign wr_accept     = resetn && data_req && data_wr && !data_busy;

`ifdef BRIDGE_RAW_ADDR_CMP_EN
  assign inst_hazard = !wr_idle && (inst_addr[31:2] == awaddr[31:2]);
`else
  assign inst_hazard = !wr_idle;
`endif

  assign inst_grant = resetn && (rd_state_q == RIdle) && inst_req && !data_rd_grant &&
                      !inst_hazard;

  // Read FSM state and latched AR payload.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_q <= RIdle;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      ar_id_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_size_q  <= ar_size_d;
      ar_id_q    <= ar_id_d;
    end
  end

  // Read arbitration, AR/R handshakes and response routing by rid.
  always_comb begin
    rd_state_d = rd_state_q;
    ar_addr_d  = ar_addr_q;
    ar_size_d  = ar_size_q;
    ar_id_d    = ar_id_q;
    arvalid    = 1'b0;
    rready     = 1'b0;
    rsp_inst   = 1'b0;
    rsp_data   = 1'b0;
    unique case (rd_state_q)
      RIdle: begin
        if (data_rd_grant) begin
          ar_addr_d  = data_addr;
          ar_size_d  = size_to_axsize(data_size);
          ar_id_d    = DATA_ID;
          rd_state_d = RAr;
        end else if (inst_grant) begin
          ar_addr_d  = inst_addr;
          ar_size_d  = size_to_axsize(inst_size);
          ar_id_d    = INST_ID;
          rd_state_d = RAr;
        end
      end
      RAr: begin
        arvalid = 1'b1;
        if (arready) rd_state_d = RWait;
      end
      RWait: begin
        rready = 1'b1;
        if (rvalid) begin
          rsp_inst   = (rid == INST_ID);
          rsp_data   = (rid == DATA_ID);
          rd_state_d = RIdle;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  sram_axi_wr_ctrl u_wr_ctrl (
    .clk       (clk),
    .resetn    (resetn),
    .accept_i  (wr_accept),
    .addr_i    (data_addr),
    .size_i    (data_size),
    .wstrb_i   (data_wstrb),
    .wdata_i   (data_wdata),
    .idle_o    (wr_idle),
    .done_o    (wr_done),
    .awaddr_o  (awaddr),
    .awsize_o  (awsize),
    .awvalid_o (awvalid),
    .awready_i (awready),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .wvalid_o  (wvalid),
    .wready_i  (wready),
    .bvalid_i  (bvalid),
    .bready_o  (bready)
  );

  assign arid         = ar_id_q;
  assign araddr       = ar_addr_q;
  assign arsize       = ar_size_q;
  assign inst_addr_ok = inst_grant;
  assign data_addr_ok = data_rd_grant || wr_accept;
  assign inst_data_ok = resetn && rsp_inst;
  assign data_data_ok = resetn && (rsp_data || wr_done);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

endmodule
